// File: rtl/alu_shift_add_mult_if.sv
// alu_shift_add_mult_if: Start/Done/Ack handshake and operand/product bus of the sequential multiplier
interface alu_shift_add_mult_if;
   logic       Start;
   logic       Ack;
   logic [3:0] Multiplicand;
   logic [3:0] Multiplier;
   logic [7:0] Product;
   logic       Busy;
   logic       Done;
   modport master(output Start, Ack, Multiplicand, Multiplier, input Product, Busy, Done);
   modport slave(input Start, Ack, Multiplicand, Multiplier, output Product, Busy, Done);
endinterface

// File: rtl/alu_shift_add_mult.sv
// alu_shift_add_mult: 4x4 shift-add multiplier iterating one alu_4_bit once per clock.
// Macro ALU_MULT_SIGNED_EN selects radix-2 Booth on two's-complement operands.
module alu_4_bit (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic [1:0] Opr,
   input  logic       AINV,
   input  logic       BNEG,
   output logic [3:0] RESULT,
   output logic       COUT,
   output logic       OVERFLOW
);
   logic [3:0] a;
   logic [3:0] b;
   logic [4:0] sum;
   always_comb begin
      a        = AINV ? ~A : A;
      b        = BNEG ? ~B : B;
      sum      = {1'b0, a} + {1'b0, b} + {4'b0, BNEG};
      OVERFLOW = (a[3] == b[3]) && (sum[3] != a[3]);
      COUT     = sum[4];
      RESULT   = Opr == 2'd0 ? a & b :
                 Opr == 2'd1 ? a | b :
                 Opr == 2'd2 ? sum[3:0] : {3'b0, sum[3] ^ OVERFLOW};
   end
endmodule

module alu_shift_add_mult (
   input logic                 Clk,
   input logic                 Reset,
   alu_shift_add_mult_if.slave bus
);
   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
   state_t     state_q, state_d;
   logic [3:0] m_q, m_d;
   logic [3:0] p_hi_q, p_hi_d;
   logic [3:0] p_lo_q, p_lo_d;
   logic [1:0] cnt_q, cnt_d;
   logic [7:0] product_q, product_d;
   logic [3:0] alu_result;
   logic       alu_cout;
   logic       alu_ovf;
   logic       alu_unused;
   logic       bneg;
   logic [3:0] hi;
   logic       c;
`ifdef ALU_MULT_SIGNED_EN
   logic       q_m1_q, q_m1_d;
   logic       step;
   assign alu_unused = alu_cout;
`else
   assign alu_unused = alu_ovf;
`endif

   alu_4_bit u_alu (
      .A(p_hi_q), .B(m_q), .Opr(2'd2), .AINV(1'b0), .BNEG(bneg),
      .RESULT(alu_result), .COUT(alu_cout), .OVERFLOW(alu_ovf)
   );

   assign bus.Product = product_q;
   assign bus.Busy    = state_q == COMPUTE;
   assign bus.Done    = state_q == DONE;

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      p_hi_d    = p_hi_q;
      p_lo_d    = p_lo_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      bneg      = 1'b0;
`ifdef ALU_MULT_SIGNED_EN
      q_m1_d    = q_m1_q;
      step      = p_lo_q[0] ^ q_m1_q;
      bneg      = state_q == COMPUTE && p_lo_q[0] && !q_m1_q;
      hi        = step ? alu_result : p_hi_q;
      // sign of the true 5-bit sum, so an overflowing subtract still shifts in correctly
      c         = step ? alu_result[3] ^ alu_ovf : p_hi_q[3];
`else
      {c, hi}   = p_lo_q[0] ? {alu_cout, alu_result} : {1'b0, p_hi_q};
`endif
      if (state_q == IDLE && bus.Start) begin
         m_d     = bus.Multiplicand;
         p_hi_d  = 4'h0;
         p_lo_d  = bus.Multiplier;
         cnt_d   = 2'd0;
`ifdef ALU_MULT_SIGNED_EN
         q_m1_d  = 1'b0;
`endif
         state_d = COMPUTE;
      end else if (state_q == COMPUTE) begin
         p_hi_d = {c, hi[3:1]};
         p_lo_d = {hi[0], p_lo_q[3:1]};
         cnt_d  = cnt_q + 2'd1;
`ifdef ALU_MULT_SIGNED_EN
         q_m1_d = p_lo_q[0];
`endif
         if (cnt_q == 2'd3) begin
            product_d = {c, hi, p_lo_q[3:1]};
            state_d   = DONE;
         end
      end else if (state_q == DONE && bus.Ack) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         m_q       <= 4'h0;
         p_hi_q    <= 4'h0;
         p_lo_q    <= 4'h0;
         cnt_q     <= 2'd0;
         product_q <= 8'h00;
`ifdef ALU_MULT_SIGNED_EN
         q_m1_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         p_hi_q    <= p_hi_d;
         p_lo_q    <= p_lo_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
`ifdef ALU_MULT_SIGNED_EN
         q_m1_q    <= q_m1_d;
`endif
      end
   end
endmodule

// File: tb/tb_alu_shift_add_mult.sv
// tb_alu_shift_add_mult: scoreboard bench for the sequential multiplier handshake and products
module tb_alu_shift_add_mult;
   logic Clk = 1'b0;
   logic Reset = 1'b1;
   alu_shift_add_mult_if bus();
   alu_shift_add_mult dut (.Clk(Clk), .Reset(Reset), .bus(bus));

   always #5 Clk = ~Clk;

   int passed = 0;
   int total  = 0;
   logic [7:0] exp_q[$];

   function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b);
`ifdef ALU_MULT_SIGNED_EN
      logic signed [7:0] sa, sb;
      sa = {{4{a[3]}}, a};
      sb = {{4{b[3]}}, b};
      return sa * sb;
`else
      return {4'b0, a} * {4'b0, b};
`endif
   endfunction

   // drive Start for one edge and push the expected product; returns at the negedge after the Start edge
   task automatic launch(input logic [3:0] a, input logic [3:0] b, input bit hold);
      @(negedge Clk);
      bus.Start = 1'b1;
      bus.Multiplicand = a;
      bus.Multiplier = b;
      exp_q.push_back(model(a, b));
      @(negedge Clk);
      bus.Start = hold;
   endtask

   task automatic wait_done(output bit seen, output int busy_n);
      seen = 1'b0;
      busy_n = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.Done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (bus.Busy === 1'b1) busy_n++;
         @(negedge Clk);
      end
   endtask

   task automatic pop_exp(output logic [7:0] e);
      e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
   endtask

   task automatic ack_pulse;
      @(negedge Clk);
      bus.Ack = 1'b1;
      @(negedge Clk);
      bus.Ack = 1'b0;
   endtask

   task automatic test_reset;
      bus.Start = 1'b0;
      bus.Ack = 1'b0;
      bus.Multiplicand = 4'h0;
      bus.Multiplier = 4'h0;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      total++;
      if ({bus.Product, bus.Busy, bus.Done} !== 10'h000)
         $display("FAIL reset: product=%h busy=%b done=%b expected 00 0 0", bus.Product, bus.Busy, bus.Done);
      else passed++;
   endtask

   task automatic test_unsigned;
      logic [3:0] av[3] = '{4'd3, 4'd15, 4'd0};
      logic [3:0] bv[3] = '{4'd4, 4'd15, 4'd9};
      bit seen;
      int busy_n;
      logic [7:0] e;
      for (int i = 0; i < 3; i++) begin
         launch(av[i], bv[i], 1'b0);
         wait_done(seen, busy_n);
         total++;
         if (!seen || busy_n != 4)
            $display("FAIL latency %0dx%0d: done=%b busy_cycles=%0d expected 1 4", av[i], bv[i], seen, busy_n);
         else passed++;
         pop_exp(e);
         total++;
         if (bus.Product !== e)
            $display("FAIL product %0dx%0d: got %h expected %h", av[i], bv[i], bus.Product, e);
         else passed++;
         ack_pulse();
      end
   endtask

   task automatic test_handshake;
      bit seen;
      int busy_n;
      int bad;
      logic [7:0] e, p;
      launch(4'd5, 4'd7, 1'b0);
      wait_done(seen, busy_n);
      pop_exp(e);
      p = bus.Product;
      total++;
      if (!seen || p !== e) $display("FAIL hs_product: done=%b got %h expected %h", seen, p, e);
      else passed++;
      bad = 0;
      repeat (10) begin
         @(negedge Clk);
         if (bus.Done !== 1'b1 || bus.Product !== e) bad++;
      end
      total++;
      if (bad != 0) $display("FAIL hs_hold: %0d unstable cycles expected 0", bad);
      else passed++;
      bus.Start = 1'b1;
      bus.Multiplicand = 4'd1;
      bus.Multiplier = 4'd1;
      @(negedge Clk);
      bus.Start = 1'b0;
      total++;
      if (bus.Done !== 1'b1 || bus.Busy !== 1'b0 || bus.Product !== e)
         $display("FAIL hs_start_in_done: done=%b busy=%b product=%h expected 1 0 %h", bus.Done, bus.Busy, bus.Product, e);
      else passed++;
      bus.Ack = 1'b1;
      @(negedge Clk);
      bus.Ack = 1'b0;
      total++;
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0)
         $display("FAIL hs_ack: done=%b busy=%b expected 0 0", bus.Done, bus.Busy);
      else passed++;
      @(negedge Clk);
      total++;
      if (bus.Busy !== 1'b0) $display("FAIL hs_idle_stays: busy=%b expected 0", bus.Busy);
      else passed++;
      launch(4'd3, 4'd3, 1'b0);
      bus.Start = 1'b1;
      bus.Multiplicand = 4'd15;
      bus.Multiplier = 4'd15;
      @(negedge Clk);
      bus.Start = 1'b0;
      wait_done(seen, busy_n);
      pop_exp(e);
      total++;
      if (!seen || bus.Product !== e)
         $display("FAIL hs_start_in_compute: done=%b got %h expected %h", seen, bus.Product, e);
      else passed++;
      ack_pulse();
   endtask

   task automatic test_reset_mid;
      bit seen;
      int busy_n;
      logic [7:0] e;
      launch(4'd7, 4'd9, 1'b0);
      void'(exp_q.pop_back());
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      total++;
      if ({bus.Product, bus.Busy, bus.Done} !== 10'h000)
         $display("FAIL reset_mid: product=%h busy=%b done=%b expected 00 0 0", bus.Product, bus.Busy, bus.Done);
      else passed++;
      repeat (5) @(negedge Clk);
      total++;
      if ({bus.Product, bus.Done} !== 9'h000)
         $display("FAIL reset_no_partial: product=%h done=%b expected 00 0", bus.Product, bus.Done);
      else passed++;
      launch(4'd2, 4'd5, 1'b0);
      wait_done(seen, busy_n);
      pop_exp(e);
      total++;
      if (!seen || bus.Product !== e) $display("FAIL after_reset 2x5: got %h expected %h", bus.Product, e);
      else passed++;
      ack_pulse();
   endtask

   task automatic test_back_to_back;
      bit seen;
      int busy_n;
      logic [7:0] e;
      launch(4'd6, 4'd6, 1'b1);
      bus.Multiplicand = 4'd5;
      bus.Multiplier = 4'd3;
      wait_done(seen, busy_n);
      pop_exp(e);
      total++;
      if (!seen || busy_n != 4 || bus.Product !== e)
         $display("FAIL b2b_first: done=%b busy=%0d got %h expected 1 4 %h", seen, busy_n, bus.Product, e);
      else passed++;
      exp_q.push_back(model(4'd5, 4'd3));
      bus.Ack = 1'b1;
      @(negedge Clk);
      bus.Ack = 1'b0;
      total++;
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0)
         $display("FAIL b2b_idle: done=%b busy=%b expected 0 0", bus.Done, bus.Busy);
      else passed++;
      @(negedge Clk);
      total++;
      if (bus.Busy !== 1'b1) $display("FAIL b2b_restart: busy=%b expected 1", bus.Busy);
      else passed++;
      bus.Start = 1'b0;
      wait_done(seen, busy_n);
      pop_exp(e);
      total++;
      if (!seen || busy_n != 4 || bus.Product !== e)
         $display("FAIL b2b_second: done=%b busy=%0d got %h expected 1 4 %h", seen, busy_n, bus.Product, e);
      else passed++;
      ack_pulse();
   endtask

`ifdef ALU_MULT_SIGNED_EN
   task automatic test_signed;
      logic [3:0] av[4] = '{4'hD, 4'h8, 4'h7, 4'hF};
      logic [3:0] bv[4] = '{4'h5, 4'h8, 4'h8, 4'hF};
      bit seen;
      int busy_n;
      logic [7:0] e;
      for (int i = 0; i < 4; i++) begin
         launch(av[i], bv[i], 1'b0);
         wait_done(seen, busy_n);
         pop_exp(e);
         total++;
         if (!seen || bus.Product !== e)
            $display("FAIL signed %h*%h: got %h expected %h", av[i], bv[i], bus.Product, e);
         else passed++;
         ack_pulse();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_unsigned();
      test_handshake();
      test_reset_mid();
      test_back_to_back();
`ifdef ALU_MULT_SIGNED_EN
      test_signed();
`endif
      total++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
